// File: rtl/imm_decode_stage_if.sv
// Handshake bundles for the immediate-decode stage: fetch side and IMM_GEN/EX side.
// Latency: none (wiring only).
// Backpressure: in_ready / out_ready carried here; the stage drives in_ready, EX drives out_ready.
//
// imm_fetch_if : fetch -> decode   (in_valid, in_ready, in_inst, in_pc)
// imm_dec_if   : decode -> IMM_GEN/EX (out_valid, out_ready, out_pc, out_opcode,
//                out_illegal, extop, immI, immS, immB, immU, immJ)

interface imm_fetch_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;

    modport master (output in_valid, output in_inst, output in_pc, input in_ready);
    modport slave  (input in_valid, input in_inst, input in_pc, output in_ready);
endinterface

interface imm_dec_if #(
    parameter int PC_W = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic            out_illegal;
    logic [2:0]      extop;
    logic [11:0]     immI;
    logic [11:0]     immS;
    logic [11:0]     immB;
    logic [19:0]     immU;
    logic [19:0]     immJ;

    modport master (output out_valid, output out_pc, output out_opcode, output out_illegal,
                    output extop, output immI, output immS, output immB, output immU,
                    output immJ, input out_ready);
    modport slave  (input out_valid, input out_pc, input out_opcode, input out_illegal,
                    input extop, input immI, input immS, input immB, input immU,
                    input immJ, output out_ready);
endinterface

// File: rtl/imm_decode_stage.sv
// Decode-stage front end: classifies the RV32I opcode and slices raw immediate fields for IMM_GEN.
// Latency: 1 cycle from input accept to out_valid when empty; no combinational in->out path.
// Backpressure: 2-entry skid (SKID_EN=1, registered in_ready) or single entry with pass-through ready.
//
// Ports: clk, rst_n (async active-low), flush (sync, highest priority),
//        fetch (imm_fetch_if.slave), dec (imm_dec_if.master).

module imm_decode_stage #(
    parameter int PC_W    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    imm_fetch_if.slave  fetch,
    imm_dec_if.master   dec
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        logic [2:0]      extop;
        logic            illegal;
    } ent_t;

    localparam logic [2:0] EXT_I    = 3'b000;
    localparam logic [2:0] EXT_U    = 3'b001;
    localparam logic [2:0] EXT_S    = 3'b010;
    localparam logic [2:0] EXT_B    = 3'b011;
    localparam logic [2:0] EXT_J    = 3'b100;
    localparam logic [2:0] EXT_NONE = 3'b111;

    localparam ent_t ENT_RST = '{pc: '0, inst: '0, extop: EXT_NONE, illegal: 1'b0};

    ent_t main_q, main_d;
    ent_t skid_q, skid_d;
    logic main_vld_q, main_vld_d;
    logic skid_vld_q, skid_vld_d;

    logic       in_rdy;
    logic       acc;
    logic       xfer;
    logic [2:0] dec_extop;
    logic       dec_illegal;
    ent_t       new_ent;

    // Opcode classification of the incoming word.
    always_comb begin
        dec_extop   = EXT_NONE;
        dec_illegal = 1'b0;
        unique case (fetch.in_inst[6:0])
            7'b0110111, 7'b0010111: dec_extop = EXT_U;
            7'b1101111:             dec_extop = EXT_J;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011: dec_extop = EXT_I;
            7'b0100011:             dec_extop = EXT_S;
            7'b1100011:             dec_extop = EXT_B;
            7'b0110011:             dec_extop = EXT_NONE;  // R-type: legal, no immediate
            default: begin
                dec_extop   = EXT_NONE;
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        new_ent = '{pc: fetch.in_pc, inst: fetch.in_inst, extop: dec_extop, illegal: dec_illegal};

        // With the skid enabled, ready depends only on local state; otherwise it
        // passes out_ready through so a single register can stream at full rate.
        if (SKID_EN) in_rdy = !skid_vld_q;
        else         in_rdy = !main_vld_q || dec.out_ready;

        acc  = fetch.in_valid && in_rdy;
        xfer = main_vld_q && dec.out_ready;

        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;

        if (flush) begin
            // Whatever was offered this cycle is dropped along with held entries.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q) begin
            // Skid is never occupied while main is empty.
            if (acc) begin
                main_vld_d = 1'b1;
                main_d     = new_ent;
            end
        end else if (xfer) begin
            if (skid_vld_q) begin
                // in_ready is low here, so no new entry can arrive this cycle.
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (acc) begin
                main_d = new_ent;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (acc) begin
            // Only reachable with SKID_EN=1: main stalled, park the newcomer.
            skid_d     = new_ent;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= ENT_RST;
            skid_q     <= ENT_RST;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign fetch.in_ready  = in_rdy;
    assign dec.out_valid   = main_vld_q;
    assign dec.out_pc      = main_q.pc;
    assign dec.out_opcode  = main_q.inst[6:0];
    assign dec.out_illegal = main_q.illegal;
    assign dec.extop       = main_q.extop;

    // Raw field slices; sign extension and shifting happen downstream.
    assign dec.immI = main_q.inst[31:20];
    assign dec.immS = {main_q.inst[31:25], main_q.inst[11:7]};
    assign dec.immB = {main_q.inst[31], main_q.inst[7], main_q.inst[30:25], main_q.inst[11:8]};
    assign dec.immU = main_q.inst[31:12];
    assign dec.immJ = {main_q.inst[31], main_q.inst[19:12], main_q.inst[20], main_q.inst[30:21]};

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed decode vectors plus
// skid ordering, flush and async-reset sequences.
// Inputs change 1 time unit after the rising edge; outputs are read there too.

module tb_imm_decode_stage;

    localparam int PC_W = 32;

    logic clk;
    logic rst_n;
    logic flush;

    imm_fetch_if #(.PC_W(PC_W)) fetch ();
    imm_dec_if   #(.PC_W(PC_W)) dec ();

    imm_decode_stage #(.PC_W(PC_W), .SKID_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .fetch (fetch),
        .dec   (dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] got_q[$];
    bit          mon_en = 1'b0;

    // A transfer happens at the next rising edge when valid & ready are seen here.
    always @(negedge clk) begin
        if (mon_en && dec.out_valid && dec.out_ready) got_q.push_back(dec.out_pc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  extop;
        logic        ill;
        logic [11:0] i_f;
        logic [11:0] s_f;
        logic [11:0] b_f;
        logic [19:0] u_f;
        logic [19:0] j_f;
    } vec_t;

    vec_t vecs[7];

    initial begin
        //                 inst          ext     ill   immI     immS     immB     immU       immJ
        vecs[0] = '{32'h00500093, 3'b000, 1'b0, 12'h005, 12'h001, 12'h400, 20'h00500, 20'h00402}; // addi
        vecs[1] = '{32'hFE000EE3, 3'b011, 1'b0, 12'hFE0, 12'hFFD, 12'hFFE, 20'hFE000, 20'h803F0}; // beq -4
        vecs[2] = '{32'h123450B7, 3'b001, 1'b0, 12'h123, 12'h121, 12'h490, 20'h12345, 20'h22C91}; // lui
        vecs[3] = '{32'h0080006F, 3'b100, 1'b0, 12'h008, 12'h000, 12'h000, 20'h00800, 20'h00004}; // jal 8
        vecs[4] = '{32'h00202423, 3'b010, 1'b0, 12'h002, 12'h008, 12'h004, 20'h00202, 20'h01001}; // sw
        vecs[5] = '{32'h002081B3, 3'b111, 1'b0, 12'h002, 12'h003, 12'h401, 20'h00208, 20'h04001}; // add
        vecs[6] = '{32'h0000007F, 3'b111, 1'b1, 12'h000, 12'h000, 12'h000, 20'h00000, 20'h00000}; // illegal

        rst_n          = 1'b0;
        flush          = 1'b0;
        fetch.in_valid = 1'b0;
        fetch.in_inst  = '0;
        fetch.in_pc    = '0;
        dec.out_ready  = 1'b0;
        #12;
        chk("rst_out_valid", {31'd0, dec.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, fetch.in_ready}, 32'd1);
        chk("rst_extop",     {29'd0, dec.extop}, 32'd7);
        chk("rst_illegal",   {31'd0, dec.out_illegal}, 32'd0);
        chk("rst_immU",      {12'd0, dec.immU}, 32'd0);
        chk("rst_out_pc",    dec.out_pc, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // ---- table-driven decode vectors ----
        dec.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            fetch.in_valid = 1'b1;
            fetch.in_inst  = vecs[k].inst;
            fetch.in_pc    = 32'h1000 + 32'(k * 4);
            chk($sformatf("v%0d_pre_valid", k), {31'd0, dec.out_valid}, 32'd0);
            step();
            fetch.in_valid = 1'b0;
            chk($sformatf("v%0d_valid", k),  {31'd0, dec.out_valid}, 32'd1);
            chk($sformatf("v%0d_pc", k),     dec.out_pc, 32'h1000 + 32'(k * 4));
            chk($sformatf("v%0d_opcode", k), {25'd0, dec.out_opcode}, {25'd0, vecs[k].inst[6:0]});
            chk($sformatf("v%0d_extop", k),  {29'd0, dec.extop}, {29'd0, vecs[k].extop});
            chk($sformatf("v%0d_illegal", k), {31'd0, dec.out_illegal}, {31'd0, vecs[k].ill});
            chk($sformatf("v%0d_immI", k),   {20'd0, dec.immI}, {20'd0, vecs[k].i_f});
            chk($sformatf("v%0d_immS", k),   {20'd0, dec.immS}, {20'd0, vecs[k].s_f});
            chk($sformatf("v%0d_immB", k),   {20'd0, dec.immB}, {20'd0, vecs[k].b_f});
            chk($sformatf("v%0d_immU", k),   {12'd0, dec.immU}, {12'd0, vecs[k].u_f});
            chk($sformatf("v%0d_immJ", k),   {12'd0, dec.immJ}, {12'd0, vecs[k].j_f});
            step();
            chk($sformatf("v%0d_drained", k), {31'd0, dec.out_valid}, 32'd0);
        end

        // ---- skid fill and strict ordering ----
        got_q.delete();
        mon_en        = 1'b1;
        dec.out_ready = 1'b0;
        fetch.in_valid = 1'b1;
        fetch.in_inst = 32'h00500093; fetch.in_pc = 32'h3000; step();
        fetch.in_inst = 32'h123450B7; fetch.in_pc = 32'h3004; step();
        chk("ord_skid_full_in_ready", {31'd0, fetch.in_ready}, 32'd0);
        fetch.in_inst = 32'h0080006F; fetch.in_pc = 32'h3008; step();
        chk("ord_stall_pc",       dec.out_pc, 32'h3000);
        chk("ord_stall_extop",    {29'd0, dec.extop}, 32'd0);
        chk("ord_stall_in_ready", {31'd0, fetch.in_ready}, 32'd0);
        dec.out_ready = 1'b1;
        step();
        chk("ord_rel_in_ready", {31'd0, fetch.in_ready}, 32'd1);
        chk("ord_rel_pc",       dec.out_pc, 32'h3004);
        step();
        fetch.in_valid = 1'b0;
        chk("ord_c_pc", dec.out_pc, 32'h3008);
        begin
            int cyc = 0;
            while (dec.out_valid && cyc < 10) begin
                step();
                cyc++;
            end
            chk("ord_drain_timeout", {31'd0, dec.out_valid}, 32'd0);
        end
        mon_en = 1'b0;
        chk("ord_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("ord_0", got_q[0], 32'h3000);
            chk("ord_1", got_q[1], 32'h3004);
            chk("ord_2", got_q[2], 32'h3008);
        end

        // ---- flush with skid full, and flush discarding a same-cycle accept ----
        got_q.delete();
        dec.out_ready  = 1'b0;
        fetch.in_valid = 1'b1;
        fetch.in_inst = 32'h00500093; fetch.in_pc = 32'h2000; step();
        fetch.in_inst = 32'h00202423; fetch.in_pc = 32'h2004; step();
        chk("fl_skid_full", {31'd0, fetch.in_ready}, 32'd0);
        flush = 1'b1; fetch.in_inst = 32'h0080006F; fetch.in_pc = 32'h2008; step();
        flush = 1'b0; fetch.in_valid = 1'b0;
        chk("fl1_out_valid", {31'd0, dec.out_valid}, 32'd0);
        chk("fl1_in_ready",  {31'd0, fetch.in_ready}, 32'd1);
        fetch.in_valid = 1'b1;
        fetch.in_inst = 32'h123450B7; fetch.in_pc = 32'h200C; step();
        chk("fl2_pre_valid", {31'd0, dec.out_valid}, 32'd1);
        flush = 1'b1; fetch.in_inst = 32'hFE000EE3; fetch.in_pc = 32'h2010; step();
        flush = 1'b0; fetch.in_valid = 1'b0;
        chk("fl2_out_valid", {31'd0, dec.out_valid}, 32'd0);
        chk("fl2_in_ready",  {31'd0, fetch.in_ready}, 32'd1);
        mon_en        = 1'b1;
        dec.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        mon_en = 1'b0;
        chk("fl_no_ghost_valid", {31'd0, dec.out_valid}, 32'd0);
        chk("fl_no_ghost_count", 32'(got_q.size()), 32'd0);

        // ---- async reset mid-stall ----
        dec.out_ready  = 1'b0;
        fetch.in_valid = 1'b1;
        fetch.in_inst = 32'h0000007F; fetch.in_pc = 32'h4000; step();
        chk("ill_valid",   {31'd0, dec.out_valid}, 32'd1);
        chk("ill_flag",    {31'd0, dec.out_illegal}, 32'd1);
        fetch.in_inst = 32'h00500093; fetch.in_pc = 32'h4004; step();
        fetch.in_valid = 1'b0;
        chk("ar_pre_in_ready", {31'd0, fetch.in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, dec.out_valid}, 32'd0);
        chk("ar_in_ready",  {31'd0, fetch.in_ready}, 32'd1);
        chk("ar_extop",     {29'd0, dec.extop}, 32'd7);
        chk("ar_illegal",   {31'd0, dec.out_illegal}, 32'd0);
        chk("ar_out_pc",    dec.out_pc, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("ar_post_valid", {31'd0, dec.out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
